// File: rtl/test_packet_gen.sv
// Test packet generator: fixed-length packets of FILL bytes with a sequence number (aux) at one offset.
// Latency: first byte on tx_en/tx_data the cycle after start is sampled; all outputs registered.
// No backpressure: the stream cannot be stalled, and stop only takes effect at a packet boundary or in a gap.
module test_packet_gen #(
  parameter int         whereis_aux = 3,
  parameter int         packetsize  = 12,
  parameter int         gap         = 10,
  parameter logic [7:0] FILL        = 8'h99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] num_packets,
  input  logic [7:0]  aux_init,
  input  logic        inject_skip,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] sent_count
);

  localparam int IW = (packetsize > 1) ? $clog2(packetsize) : 1;
  localparam int GW = (gap > 1) ? $clog2(gap) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(packetsize - 1);
  localparam logic [IW-1:0] AUX_IDX  = IW'(whereis_aux);
  localparam logic [GW-1:0] LAST_GAP = GW'(gap - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  // r_state/r_idx/r_gcnt describe what is on the wire during the current cycle
  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_idx,   w_idx_nxt;
  logic [GW-1:0] r_gcnt,  w_gcnt_nxt;
  logic [7:0]    r_aux,   w_aux_nxt;
  logic          r_skip,  w_skip_nxt;
  logic [31:0]   r_num,   w_num_nxt;
  logic [31:0]   r_sent,  w_sent_nxt;
  logic [31:0]   w_sent_inc;
  logic          r_tx_en, w_tx_en_nxt;
  logic [7:0]    r_tx_dat, w_tx_dat_nxt;
  logic          r_busy,  w_busy_nxt;
  logic          r_done,  w_done_nxt;

  // Next-state and next-output decode; outputs are derived from the next state so they register cleanly
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_gcnt_nxt  = r_gcnt;
    w_aux_nxt   = r_aux;
    w_skip_nxt  = r_skip;
    w_num_nxt   = r_num;
    w_sent_nxt  = r_sent;
    w_done_nxt  = 1'b0;
    w_sent_inc  = r_sent + 32'd1;

    unique case (r_state)
      S_IDLE: begin
        // start beats a simultaneous stop; stop is only looked at once a packet is under way
        if (start) begin
          w_state_nxt = S_SEND;
          w_idx_nxt   = '0;
          w_aux_nxt   = aux_init;
          w_num_nxt   = num_packets;
          w_sent_nxt  = '0;
          w_skip_nxt  = 1'b0;
        end
      end
      S_SEND: begin
        // skip request only counts at the first byte of each packet
        if (r_idx == '0) w_skip_nxt = inject_skip;
        if (r_idx == LAST_IDX) begin
          w_sent_nxt = w_sent_inc;
          w_aux_nxt  = r_aux + (r_skip ? 8'd2 : 8'd1);
          w_idx_nxt  = '0;
          w_gcnt_nxt = '0;
          if (stop || (r_num != 32'd0 && w_sent_inc == r_num)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_GAP;
          end
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      S_GAP: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_gcnt == LAST_GAP) begin
          w_state_nxt = S_SEND;
          w_idx_nxt   = '0;
        end else begin
          w_gcnt_nxt = r_gcnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_tx_en_nxt  = (w_state_nxt == S_SEND);
    w_tx_dat_nxt = !w_tx_en_nxt ? 8'h00 : ((w_idx_nxt == AUX_IDX) ? w_aux_nxt : FILL);
    w_busy_nxt   = (w_state_nxt != S_IDLE);
  end

  // State, datapath and output registers; reset truncates any packet in flight immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_gcnt   <= '0;
      r_aux    <= 8'h00;
      r_skip   <= 1'b0;
      r_num    <= 32'd0;
      r_sent   <= 32'd0;
      r_tx_en  <= 1'b0;
      r_tx_dat <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_gcnt   <= w_gcnt_nxt;
      r_aux    <= w_aux_nxt;
      r_skip   <= w_skip_nxt;
      r_num    <= w_num_nxt;
      r_sent   <= w_sent_nxt;
      r_tx_en  <= w_tx_en_nxt;
      r_tx_dat <= w_tx_dat_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign tx_en      = r_tx_en;
  assign tx_data    = r_tx_dat;
  assign busy       = r_busy;
  assign done       = r_done;
  assign sent_count = r_sent;

endmodule

// File: tb/tb_test_packet_gen.sv
// Self-checking bench for test_packet_gen: table of bursts, hand-written reset sequence,
// randomized bursts against a cycle-position model, and a receiver-side loopback counter.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_test_packet_gen;

  localparam int         PS    = 12;
  localparam int         GAPC  = 10;
  localparam int         P     = PS + GAPC;
  localparam int         WA    = 3;
  localparam logic [7:0] FILLV = 8'h99;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [31:0] num_packets;
  logic [7:0]  aux_init;
  logic        inject_skip;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;
  logic [31:0] sent_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit skip_arr [0:511];

  test_packet_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .num_packets(num_packets),
    .aux_init(aux_init), .inject_skip(inject_skip), .tx_en(tx_en), .tx_data(tx_data),
    .busy(busy), .done(done), .sent_count(sent_count)
  );

  always #4 clk = ~clk;

  initial begin
    #(8 * 90000);
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Burst length in cycles from the first byte until done is seen
  function automatic int model_len(input int n, input int cs);
    int l, q, off, ls;
    l = 32'h7fffffff;
    if (n != 0) l = (n - 1) * P + PS;
    if (cs >= 0) begin
      q   = cs / P;
      off = cs % P;
      ls  = (off < PS) ? q * P + PS : cs + 1;
      if (ls < l) l = ls;
    end
    return l;
  endfunction

  // Sequence number of packet q: one per packet plus one extra per earlier skipped packet
  function automatic logic [7:0] model_aux(input logic [7:0] a0, input int q);
    int s;
    s = int'(a0) + q;
    for (int i = 0; i < q; i++) if (skip_arr[i]) s++;
    return 8'(s);
  endfunction

  // Runs one burst, checking every cycle against the model; reports what a receiver would see
  task automatic run_burst(input int n, input logic [7:0] a0, input int cs, input string tag,
                           output int obs_done, output int obs_sent, output logic [7:0] last_aux,
                           output int rx_pkts, output int rx_errs);
    int L, q, off, ridx, exp_sent;
    logic prev_en;
    logic [7:0] prev_aux, exp_dat;
    logic exp_en;
    L = model_len(n, cs);
    obs_done = -1; obs_sent = -1; last_aux = 8'h00; rx_pkts = 0; rx_errs = 0;
    ridx = 0; prev_en = 1'b0; prev_aux = 8'h00;
    start = 1'b1; num_packets = 32'(n); aux_init = a0; stop = (cs == 0);
    inject_skip = 1'($urandom % 2);
    tick();
    for (int c = 0; c <= L + 1; c++) begin
      q = c / P;
      off = c % P;
      exp_en   = (c < L) && (off < PS);
      exp_dat  = !exp_en ? 8'h00 : ((off == WA) ? model_aux(a0, q) : FILLV);
      exp_sent = (c < PS) ? 0 : (c - PS) / P + 1;
      chk($sformatf("%s c%0d tx_en", tag, c), 32'(tx_en), 32'(exp_en));
      chk($sformatf("%s c%0d tx_data", tag, c), 32'(tx_data), 32'(exp_dat));
      chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(c < L));
      chk($sformatf("%s c%0d done", tag, c), 32'(done), 32'(c == L));
      chk($sformatf("%s c%0d sent_count", tag, c), sent_count, 32'(exp_sent));
      if (done && obs_done < 0) begin
        obs_done = c;
        obs_sent = int'(sent_count);
      end
      if (tx_en) begin
        ridx = prev_en ? ridx + 1 : 0;
        if (ridx == WA) begin
          if (rx_pkts > 0 && tx_data != 8'(prev_aux + 8'd1)) rx_errs++;
          prev_aux = tx_data;
          last_aux = tx_data;
          rx_pkts++;
        end
      end
      prev_en = tx_en;
      stop        = (cs >= 0) && (c >= cs) && (c < L);
      inject_skip = (c < L && off == 0) ? skip_arr[q] : 1'($urandom % 2);
      num_packets = $urandom;
      aux_init    = 8'($urandom);
      start       = (c < L) ? ($urandom % 8 == 0) : 1'b0;
      tick();
    end
    start = 1'b0; stop = 1'b0; inject_skip = 1'b0;
  endtask

  typedef struct {
    int         n;
    logic [7:0] a0;
    int         cs;
    int         skip_pkt;
    int         exp_len;
    int         exp_sent;
    logic [7:0] exp_last;
    int         exp_errs;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int od, os, rp, re;
    logic [7:0] la;

    vecs[0] = '{n: 3, a0: 8'h05, cs: -1, skip_pkt: -1, exp_len: 56,  exp_sent: 3, exp_last: 8'h07, exp_errs: 0};
    vecs[1] = '{n: 4, a0: 8'hFE, cs: -1, skip_pkt: -1, exp_len: 78,  exp_sent: 4, exp_last: 8'h01, exp_errs: 0};
    vecs[2] = '{n: 4, a0: 8'h00, cs: -1, skip_pkt: 1,  exp_len: 78,  exp_sent: 4, exp_last: 8'h04, exp_errs: 1};
    vecs[3] = '{n: 0, a0: 8'h00, cs: 94, skip_pkt: -1, exp_len: 100, exp_sent: 5, exp_last: 8'h04, exp_errs: 0};
    vecs[4] = '{n: 0, a0: 8'h42, cs: 0,  skip_pkt: -1, exp_len: 12,  exp_sent: 1, exp_last: 8'h42, exp_errs: 0};
    vecs[5] = '{n: 0, a0: 8'h10, cs: 37, skip_pkt: -1, exp_len: 38,  exp_sent: 2, exp_last: 8'h11, exp_errs: 0};
    vecs[6] = '{n: 0, a0: 8'h20, cs: 55, skip_pkt: -1, exp_len: 56,  exp_sent: 3, exp_last: 8'h22, exp_errs: 0};
    vecs[7] = '{n: 1, a0: 8'hFF, cs: -1, skip_pkt: 0,  exp_len: 12,  exp_sent: 1, exp_last: 8'hFF, exp_errs: 0};

    rst = 1'b0; start = 1'b0; stop = 1'b0; num_packets = 32'd0; aux_init = 8'h00; inject_skip = 1'b0;
    repeat (3) tick();
    chk("reset tx_en", 32'(tx_en), 32'd0);
    chk("reset tx_data", 32'(tx_data), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sent_count", sent_count, 32'd0);
    rst = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 512; i++) skip_arr[i] = 1'b0;
      if (vecs[v].skip_pkt >= 0) skip_arr[vecs[v].skip_pkt] = 1'b1;
      run_burst(vecs[v].n, vecs[v].a0, vecs[v].cs, $sformatf("vec%0d", v), od, os, la, rp, re);
      chk($sformatf("vec%0d done cycle", v), 32'(od), 32'(vecs[v].exp_len));
      chk($sformatf("vec%0d final sent", v), 32'(os), 32'(vecs[v].exp_sent));
      chk($sformatf("vec%0d last aux", v), 32'(la), 32'(vecs[v].exp_last));
      chk($sformatf("vec%0d rx errors", v), 32'(re), 32'(vecs[v].exp_errs));
      repeat (2) tick();
    end

    // Asynchronous reset at idx 6 of the second packet of a continuous burst
    for (int i = 0; i < 512; i++) skip_arr[i] = 1'b0;
    start = 1'b1; num_packets = 32'd0; aux_init = 8'h33;
    tick();
    start = 1'b0;
    repeat (P + 6) tick();
    chk("pre-reset tx_en", 32'(tx_en), 32'd1);
    chk("pre-reset sent_count", sent_count, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async reset tx_en", 32'(tx_en), 32'd0);
    chk("async reset tx_data", 32'(tx_data), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset done", 32'(done), 32'd0);
    chk("async reset sent_count", sent_count, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post-reset idle tx_en", 32'(tx_en), 32'd0);
    run_burst(2, 8'h77, -1, "restart", od, os, la, rp, re);
    chk("restart done cycle", 32'(od), 32'd34);
    chk("restart last aux", 32'(la), 32'h78);
    chk("restart rx packets", 32'(rp), 32'd2);

    // Randomized bursts: counted, stopped, or both, with random skips
    for (int r = 0; r < 16; r++) begin
      int n, cs;
      logic [7:0] a0;
      for (int i = 0; i < 512; i++) skip_arr[i] = ($urandom % 4 == 0);
      n  = $urandom_range(0, 5);
      a0 = 8'($urandom);
      if (n == 0) cs = $urandom_range(0, 130);
      else        cs = ($urandom % 2 == 1) ? $urandom_range(0, n * P) : -1;
      run_burst(n, a0, cs, $sformatf("rnd%0d", r), od, os, la, rp, re);
      chk($sformatf("rnd%0d done cycle", r), 32'(od), 32'(model_len(n, cs)));
      repeat ($urandom_range(0, 3)) tick();
    end

    // Loopback: 300 packets seen by an in-order receiver, then the same with one skip
    for (int i = 0; i < 512; i++) skip_arr[i] = 1'b0;
    run_burst(300, 8'h00, -1, "loop", od, os, la, rp, re);
    chk("loop rx packets", 32'(rp), 32'd300);
    chk("loop rx errors", 32'(re), 32'd0);
    chk("loop sent_count", 32'(os), 32'd300);
    skip_arr[150] = 1'b1;
    run_burst(300, 8'h00, -1, "loopskip", od, os, la, rp, re);
    chk("loopskip rx packets", 32'(rp), 32'd300);
    chk("loopskip rx errors", 32'(re), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
